// File: rtl/mega_sreg.sv
// ---------------------------------------------------------------------------
// mega_sreg -- XMEGA status register unit
//
// Holds the eight SREG flags {I,T,H,S,V,N,Z,C} and feeds them back to the
// ALU. Each cycle the next value is built in three stages:
//   1. per-flag merge of the ALU outputs under alu_flags_we,
//   2. whole-byte override by an I/O write to IO_ADDR,
//   3. interrupt entry (clear I) / RETI (set I, or restore from shadow).
//
// Optional feature macro: SREG_SHADOW_EN
//   defined   -> a SHADOW_DEPTH-entry hardware LIFO saves SREG on interrupt
//                entry and restores it on RETI.
//   undefined -> plain AVR behaviour, no storage; shadow status outputs are
//                tied to full=0, empty=1, err=0.
//
// Parameters:
//   SHADOW_DEPTH  nesting levels held in the shadow LIFO (1..16)
//   IO_ADDR       I/O address decoded as SREG
//
// Ports:
//   clk           core clock, rising edge
//   rst           synchronous active-low reset
//   alu_flags     ALU flag outputs {I,T,H,S,V,N,Z,C}
//   alu_flags_we  per-flag commit mask for alu_flags
//   sreg          registered SREG value
//   io_addr       I/O address
//   io_wr/io_rd   I/O write / read strobes
//   io_din        I/O write data
//   io_dout       registered I/O read data (0 when not reading SREG)
//   irq_entry     pulse on interrupt vectoring
//   reti          pulse when RETI retires
//   shadow_full   LIFO holds SHADOW_DEPTH entries
//   shadow_empty  LIFO holds no entries
//   shadow_err    sticky push-on-full / pop-on-empty / entry+RETI collision
// ---------------------------------------------------------------------------
module mega_sreg #(
    parameter int         SHADOW_DEPTH = 4,
    parameter logic [5:0] IO_ADDR      = 6'h3F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] alu_flags,
    input  logic [7:0] alu_flags_we,
    output logic [7:0] sreg,
    input  logic [5:0] io_addr,
    input  logic       io_wr,
    input  logic       io_rd,
    input  logic [7:0] io_din,
    output logic [7:0] io_dout,
    input  logic       irq_entry,
    input  logic       reti,
    output logic       shadow_full,
    output logic       shadow_empty,
    output logic       shadow_err
);

    logic [7:0] sreg_r;
    logic [7:0] io_dout_r;
    logic [7:0] alu_merge_s;
    logic [7:0] merge_s;
    logic [7:0] sreg_next_s;
    logic [7:0] io_dout_next_s;
    logic       io_hit_s;

    assign io_hit_s = (io_addr == IO_ADDR);

    // Merge ALU flags under the commit mask, then let an I/O write replace the byte
    always_comb begin
        alu_merge_s = (sreg_r & ~alu_flags_we) | (alu_flags & alu_flags_we);
        if (io_wr && io_hit_s) begin
            merge_s = io_din;
        end else begin
            merge_s = alu_merge_s;
        end
    end

    // I/O read returns the pre-update SREG; zero otherwise
    always_comb begin
        if (io_rd && io_hit_s) begin
            io_dout_next_s = sreg_r;
        end else begin
            io_dout_next_s = 8'h00;
        end
    end

`ifdef SREG_SHADOW_EN

    localparam int PTR_W = $clog2(SHADOW_DEPTH + 32'sd1);
    localparam int IDX_W = (SHADOW_DEPTH > 32'sd1) ? $clog2(SHADOW_DEPTH) : 32'sd1;
    localparam logic [PTR_W-1:0] DEPTH_PTR = PTR_W'(SHADOW_DEPTH);

    // Only bits [6:0] are stored: a restore always forces I=1, so the saved I
    // bit would never be read back.
    logic [6:0]       stack_r [0:SHADOW_DEPTH-1];
    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] ptr_next_s;
    logic [PTR_W-1:0] top_ptr_s;
    logic [IDX_W-1:0] push_idx_s;
    logic [IDX_W-1:0] pop_idx_s;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             err_set_s;
    logic             err_r;

    assign full_s     = (ptr_r == DEPTH_PTR);
    assign empty_s    = (ptr_r == {PTR_W{1'b0}});
    assign top_ptr_s  = ptr_r - PTR_W'(1'b1);
    // The pointer is below DEPTH whenever these indices are used, so the low
    // bits address the array directly.
    assign push_idx_s = ptr_r[IDX_W-1:0];
    assign pop_idx_s  = top_ptr_s[IDX_W-1:0];

    // Interrupt entry / RETI next-state with shadow LIFO push and pop
    always_comb begin
        sreg_next_s = merge_s;
        ptr_next_s  = ptr_r;
        push_s      = 1'b0;
        err_set_s   = 1'b0;
        if (irq_entry) begin
            // Entry wins over a simultaneous RETI; the collision is an error.
            sreg_next_s = {1'b0, merge_s[6:0]};
            err_set_s   = reti | full_s;
            if (!full_s) begin
                push_s     = 1'b1;
                ptr_next_s = ptr_r + PTR_W'(1'b1);
            end else begin
                push_s     = 1'b0;
                ptr_next_s = ptr_r;
            end
        end else if (reti) begin
            if (!empty_s) begin
                sreg_next_s = {1'b1, stack_r[pop_idx_s]};
                ptr_next_s  = top_ptr_s;
                err_set_s   = 1'b0;
            end else begin
                sreg_next_s = {1'b1, merge_s[6:0]};
                ptr_next_s  = ptr_r;
                err_set_s   = 1'b1;
            end
        end else begin
            sreg_next_s = merge_s;
            ptr_next_s  = ptr_r;
        end
    end

    // LIFO pointer and sticky error; reset empties the LIFO
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_r <= {PTR_W{1'b0}};
            err_r <= 1'b0;
        end else begin
            ptr_r <= ptr_next_s;
            err_r <= err_r | err_set_s;
        end
    end

    // LIFO storage; contents are don't-care while the pointer excludes them
    always_ff @(posedge clk) begin
        if (push_s) begin
            stack_r[push_idx_s] <= merge_s[6:0];
        end
    end

    assign shadow_full  = full_s;
    assign shadow_empty = empty_s;
    assign shadow_err   = err_r;

`else

    // Interrupt entry clears I, RETI sets I; entry wins when both occur
    always_comb begin
        if (irq_entry) begin
            sreg_next_s = {1'b0, merge_s[6:0]};
        end else if (reti) begin
            sreg_next_s = {1'b1, merge_s[6:0]};
        end else begin
            sreg_next_s = merge_s;
        end
    end

    assign shadow_full  = 1'b0;
    assign shadow_empty = 1'b1;
    assign shadow_err   = 1'b0;

`endif

    // SREG and I/O read data registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            sreg_r    <= 8'h00;
            io_dout_r <= 8'h00;
        end else begin
            sreg_r    <= sreg_next_s;
            io_dout_r <= io_dout_next_s;
        end
    end

    assign sreg    = sreg_r;
    assign io_dout = io_dout_r;

endmodule

// File: tb/tb_mega_sreg.sv
// ---------------------------------------------------------------------------
// tb_mega_sreg -- self-checking bench for mega_sreg
//
// A behavioural model (plain byte arithmetic plus a queue standing in for the
// shadow stack) predicts every output after each clock. Directed steps cover
// the key scenarios with fixed expected constants, followed by a randomized
// run checked against the model. Builds with or without SREG_SHADOW_EN.
// ---------------------------------------------------------------------------
module tb_mega_sreg;

    localparam int         DEPTH = 4;
    localparam logic [5:0] SADDR = 6'h3F;

    logic       clk;
    logic       rst;
    logic [7:0] alu_flags;
    logic [7:0] alu_flags_we;
    logic [7:0] sreg;
    logic [5:0] io_addr;
    logic       io_wr;
    logic       io_rd;
    logic [7:0] io_din;
    logic [7:0] io_dout;
    logic       irq_entry;
    logic       reti;
    logic       shadow_full;
    logic       shadow_empty;
    logic       shadow_err;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [7:0] m_sreg = 8'h00;
    logic       m_err  = 1'b0;
    logic [7:0] m_stack [$];

    mega_sreg #(.SHADOW_DEPTH(DEPTH), .IO_ADDR(SADDR)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_flags    (alu_flags),
        .alu_flags_we (alu_flags_we),
        .sreg         (sreg),
        .io_addr      (io_addr),
        .io_wr        (io_wr),
        .io_rd        (io_rd),
        .io_din       (io_din),
        .io_dout      (io_dout),
        .irq_entry    (irq_entry),
        .reti         (reti),
        .shadow_full  (shadow_full),
        .shadow_empty (shadow_empty),
        .shadow_err   (shadow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, predict, check after the rise
    task automatic cyc(input logic r, input logic [7:0] f, input logic [7:0] we,
                       input logic [5:0] a, input logic w, input logic rd,
                       input logic [7:0] d, input logic ie, input logic rt);
        logic [7:0] m;
        logic [7:0] nxt;
        logic [7:0] dout_e;
        logic       full_e;
        logic       empty_e;
        @(negedge clk);
        rst = r; alu_flags = f; alu_flags_we = we; io_addr = a;
        io_wr = w; io_rd = rd; io_din = d; irq_entry = ie; reti = rt;
        if (!r) begin
            nxt = 8'h00;
            dout_e = 8'h00;
            m_err = 1'b0;
            m_stack.delete();
        end else begin
            m = (m_sreg & ~we) | (f & we);
            if (w && a == SADDR) m = d;
            dout_e = (rd && a == SADDR) ? m_sreg : 8'h00;
`ifdef SREG_SHADOW_EN
            if (ie) begin
                if (rt) m_err = 1'b1;
                if (m_stack.size() == DEPTH) m_err = 1'b1;
                else m_stack.push_back(m);
                nxt = m & 8'h7F;
            end else if (rt) begin
                if (m_stack.size() > 0) nxt = m_stack.pop_back() | 8'h80;
                else begin
                    nxt = m | 8'h80;
                    m_err = 1'b1;
                end
            end else begin
                nxt = m;
            end
`else
            if (ie) nxt = m & 8'h7F;
            else if (rt) nxt = m | 8'h80;
            else nxt = m;
`endif
        end
`ifdef SREG_SHADOW_EN
        full_e  = (m_stack.size() == DEPTH);
        empty_e = (m_stack.size() == 0);
`else
        full_e  = 1'b0;
        empty_e = 1'b1;
`endif
        @(posedge clk);
        #1;
        m_sreg = nxt;
        chk("sreg", sreg, m_sreg);
        chk("io_dout", io_dout, dout_e);
        chk("shadow_full", {7'd0, shadow_full}, {7'd0, full_e});
        chk("shadow_empty", {7'd0, shadow_empty}, {7'd0, empty_e});
        chk("shadow_err", {7'd0, shadow_err}, {7'd0, m_err});
    endtask

    // Convenience steps
    task automatic idle();
        cyc(1'b1, 8'h00, 8'h00, 6'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask
    task automatic wr_sreg(input logic [7:0] v);
        cyc(1'b1, 8'h00, 8'h00, SADDR, 1'b1, 1'b0, v, 1'b0, 1'b0);
    endtask
    task automatic irq();
        cyc(1'b1, 8'h00, 8'h00, 6'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask
    task automatic ret();
        cyc(1'b1, 8'h00, 8'h00, 6'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b0; alu_flags = 8'h00; alu_flags_we = 8'h00; io_addr = 6'h00;
        io_wr = 1'b0; io_rd = 1'b0; io_din = 8'h00; irq_entry = 1'b0; reti = 1'b0;

        // Reset
        cyc(1'b0, 8'h00, 8'h00, 6'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'hFF, 8'hFF, SADDR, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
        chk("reset_sreg", sreg, 8'h00);
        chk("reset_empty", {7'd0, shadow_empty}, 8'h01);

        // Masked ALU commit, then I/O read
        cyc(1'b1, 8'hFF, 8'h03, 6'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("plan_commit", sreg, 8'h03);
        cyc(1'b1, 8'h00, 8'h00, SADDR, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("plan_read", io_dout, 8'h03);
        idle();
        chk("read_cleared", io_dout, 8'h00);

        // I/O write overrides a full ALU commit; read in the same cycle sees old value
        cyc(1'b1, 8'h00, 8'hFF, SADDR, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        chk("plan_io_over_alu", sreg, 8'hA5);
        chk("plan_rd_old", io_dout, 8'h03);

        // Write to another address is ignored
        cyc(1'b1, 8'h00, 8'h00, 6'h3E, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        chk("other_addr", sreg, 8'hA5);

        // Entry clears I, RETI sets it (and restores the saved byte with shadow)
        wr_sreg(8'h81);
        irq();
        chk("plan_entry", sreg, 8'h01);
`ifdef SREG_SHADOW_EN
        chk("entry_nonempty", {7'd0, shadow_empty}, 8'h00);
`else
        chk("entry_empty", {7'd0, shadow_empty}, 8'h01);
`endif
        ret();
        chk("plan_reti", sreg, 8'h81);
        chk("reti_empty", {7'd0, shadow_empty}, 8'h01);

        // Save across a flag change
        wr_sreg(8'h83);
        irq();
        chk("entry_83", sreg, 8'h03);
        cyc(1'b1, 8'h1C, 8'hFF, 6'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("commit_1c", sreg, 8'h1C);
        ret();
`ifdef SREG_SHADOW_EN
        chk("restore_83", sreg, 8'h83);
`else
        chk("reti_9c", sreg, 8'h9C);
`endif

        // Nesting past the depth, then unwind
        wr_sreg(8'h90);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'(i + 1), 8'h0F, 6'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
`ifdef SREG_SHADOW_EN
            if (i == 3) chk("full_after_4", {7'd0, shadow_full}, 8'h01);
            if (i == 4) chk("err_after_5", {7'd0, shadow_err}, 8'h01);
`endif
        end
        for (int i = 0; i < 4; i++) ret();

        // RETI on an empty LIFO
        wr_sreg(8'h02);
        ret();
        chk("empty_reti", sreg, 8'h82);
`ifdef SREG_SHADOW_EN
        chk("empty_reti_err", {7'd0, shadow_err}, 8'h01);
`endif

        // Simultaneous entry and RETI
        cyc(1'b1, 8'h00, 8'h00, 6'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("collide_i0", sreg, 8'h02);

        // Reset mid-nesting
        irq();
        cyc(1'b0, 8'h00, 8'h00, 6'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_sreg", sreg, 8'h00);
        chk("rst_err", {7'd0, shadow_err}, 8'h00);
        ret();
        chk("post_rst_reti", sreg, 8'h80);

        // Randomized run against the model
        for (int i = 0; i < 600; i++) begin
            logic [5:0] a;
            a = ($urandom_range(0, 1) == 0) ? SADDR : 6'($urandom_range(0, 63));
            cyc(($urandom_range(0, 49) != 0),
                8'($urandom), 8'($urandom), a,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                8'($urandom),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mega_sreg.md
# mega_sreg

Status register unit for the XMEGA core: holds the eight SREG flags {I,T,H,S,V,N,Z,C} and feeds them back to the ALU's flag inputs. It commits the ALU's per-flag outputs under a write mask and serves SREG reads and writes over the I/O bus. It also handles I-flag changes on interrupt entry and RETI, with an optional hardware shadow stack that saves and restores SREG across nested interrupts.

## Interface
- `SHADOW_DEPTH`, 4: number of nesting levels held in the shadow LIFO (1–16).
- `IO_ADDR`, 6'h3F: I/O-space address decoded as SREG.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `alu_flags`  in  8  ALU flag outputs, bit order {I,T,H,S,V,N,Z,C} = [7:0].
- `alu_flags_we`  in  8  per-flag commit mask for `alu_flags`; bit n=1 loads flag n.
- `sreg`  out  8  current SREG, registered; drives the ALU `*_IN` flag inputs.
- `io_addr`  in  6  I/O address.
- `io_wr`  in  1  I/O write strobe.
- `io_rd`  in  1  I/O read strobe.
- `io_din`  in  8  I/O write data.
- `io_dout`  out  8  I/O read data, registered.
- `irq_entry`  in  1  one-cycle pulse when the core vectors to an interrupt.
- `reti`  in  1  one-cycle pulse when RETI retires.
- `shadow_full`  out  1  shadow LIFO holds `SHADOW_DEPTH` entries.
- `shadow_empty`  out  1  shadow LIFO holds 0 entries.
- `shadow_err`  out  1  sticky flag for a push on full or a pop on empty.

## Operation
- Reset values (`rst`=0 at an edge): `sreg`=8'h00, `io_dout`=8'h00, LIFO pointer=0, `shadow_empty`=1, `shadow_full`=0, `shadow_err`=0.
- Each cycle, next-state is evaluated in this order:
  1. merge: m = (`sreg` & ~`alu_flags_we`) | (`alu_flags` & `alu_flags_we`).
  2. I/O write: if `io_wr` and `io_addr`==`IO_ADDR`, then m = `io_din`. The I/O write overrides the ALU commit for the whole byte.
  3. Interrupt events, as below.
- `irq_entry` (takes priority over `reti`):
  - push m into the LIFO;
  - `sreg` <= m with I=0.
- `reti` without `irq_entry`:
  - if the LIFO is non-empty, pop the top entry t and set `sreg` <= t with I=1. The same-cycle merge result m is discarded.
- `irq_entry` and `reti` asserted in the same cycle: `reti` is ignored and `shadow_err` is set.
- Push while full: the push is dropped and the existing entries are kept. `shadow_err` is set. I is still cleared.
- Pop while empty: `sreg` <= m with I=1. `shadow_err` is set.
- `shadow_err` clears only on reset.
- I/O read: if `io_rd` and `io_addr`==`IO_ADDR`, then `io_dout` <= `sreg` (the pre-update value); otherwise `io_dout` <= 0.
- `io_wr` and `io_rd` to SREG in the same cycle: the read returns the old value and the write takes effect.
- `shadow_full` and `shadow_empty` are decoded combinationally from the registered pointer.

## Timing
- `sreg` reflects a commit, I/O write, entry or RETI exactly one cycle after the qualifying input edge.
- `io_dout` has 1-cycle read latency and is valid only in the cycle after `io_rd`.
- Back-to-back `irq_entry` on consecutive cycles performs consecutive pushes. The second push saves the I=0 value produced by the first.
- `reti` on the cycle after `irq_entry` restores the value just pushed.
- Reset mid-nesting discards all LIFO contents. Reset takes priority over every other input.

## Configuration
- `SREG_SHADOW_EN` defined: the LIFO described above is built.
- `SREG_SHADOW_EN` undefined (standard AVR behaviour, software saves SREG):
  - no storage is built;
  - `irq_entry` gives `sreg` <= m with I=0;
  - `reti` gives `sreg` <= m with I=1;
  - simultaneous `irq_entry` and `reti`: I=0;
  - `shadow_full`=0, `shadow_empty`=1, `shadow_err`=0 constantly.

## Test plan
- Reset, then `alu_flags`=8'hFF with `alu_flags_we`=8'h03 → `sreg`=8'h03 next cycle; then `io_rd` at 0x3F → `io_dout`=8'h03 one cycle later.
- Same cycle: `io_wr` of 8'hA5 at 0x3F, `alu_flags_we`=8'hFF, `alu_flags`=8'h00 → `sreg`=8'hA5.
- With shadow enabled, `sreg`=8'h83, pulse `irq_entry` → `sreg`=8'h03 and `shadow_empty`=0. Commit 8'h1C with mask 8'hFF → `sreg`=8'h1C. Pulse `reti` → `sreg`=8'h83 and `shadow_empty`=1.
- With `SHADOW_DEPTH`=4, five `irq_entry` pulses → `shadow_full`=1 after the 4th, `shadow_err`=1 after the 5th. Then four `reti` pulses restore the values in reverse push order.
- `reti` with the LIFO empty and `sreg`=8'h02 → `sreg`=8'h82, `shadow_err`=1. Then `rst`=0 for one cycle → all outputs return to their reset values.
- Macro undefined: `sreg`=8'h81, `irq_entry` → 8'h01, `reti` → 8'h81. `shadow_empty` stays 1 throughout.
